// File: rtl/dm_sba_axil_bridge.sv
// Bridges the debug module's system-bus host port (req/gnt/r_valid) onto a single
// AXI4-Lite master. One access in flight; completion is pulsed back for reads and writes.
module dm_sba_axil_bridge #(
    parameter int BusWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    host_req_i,
    input  logic [BusWidth-1:0]     host_add_i,
    input  logic                    host_we_i,
    input  logic [BusWidth-1:0]     host_wdata_i,
    input  logic [BusWidth/8-1:0]   host_be_i,
    output logic                    host_gnt_o,
    output logic                    host_r_valid_o,
    output logic [BusWidth-1:0]     host_r_rdata_o,
    output logic                    host_r_err_o,
    output logic [BusWidth-1:0]     m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [BusWidth-1:0]     m_axi_wdata,
    output logic [BusWidth/8-1:0]   m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [BusWidth-1:0]     m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [BusWidth-1:0]     m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    generate
        if (BusWidth != 32) begin : g_width_check
            $error("dm_sba_axil_bridge: only BusWidth = 32 is supported");
        end
    endgenerate

    logic [2:0]            state_r;
    logic [BusWidth-1:0]   awaddr_r;
    logic [BusWidth-1:0]   wdata_r;
    logic [BusWidth/8-1:0] wstrb_r;
    logic [BusWidth-1:0]   araddr_r;
    logic                  awvalid_r;
    logic                  wvalid_r;
    logic                  bready_r;
    logic                  arvalid_r;
    logic                  rready_r;
    logic                  aw_done_r;
    logic                  w_done_r;
    logic                  r_valid_r;
    logic                  r_err_r;
    logic [BusWidth-1:0]   r_rdata_r;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic [BusWidth-1:0]   aligned_addr_s;
    logic [1:0]            unused_addr_s;

    // Sub-word selection travels only on wstrb, so the AXI address is word aligned.
    assign aligned_addr_s = {host_add_i[BusWidth-1:2], 2'b00};
    assign unused_addr_s  = host_add_i[1:0];
    assign aw_hs_s        = awvalid_r && m_axi_awready;
    assign w_hs_s         = wvalid_r && m_axi_wready;

    assign host_gnt_o     = (state_r == IDLE) && host_req_i && !rst_i;
    assign busy_o         = (state_r != IDLE);
    assign host_r_valid_o = r_valid_r;
    assign host_r_err_o   = r_err_r;
    assign host_r_rdata_o = r_rdata_r;
    assign m_axi_awaddr   = awaddr_r;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awvalid  = awvalid_r;
    assign m_axi_wdata    = wdata_r;
    assign m_axi_wstrb    = wstrb_r;
    assign m_axi_wvalid   = wvalid_r;
    assign m_axi_bready   = bready_r;
    assign m_axi_araddr   = araddr_r;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arvalid  = arvalid_r;
    assign m_axi_rready   = rready_r;

    // Access sequencer: every AXI handshake signal and host response is a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            awaddr_r  <= {BusWidth{1'b0}};
            wdata_r   <= {BusWidth{1'b0}};
            wstrb_r   <= {(BusWidth/8){1'b0}};
            araddr_r  <= {BusWidth{1'b0}};
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            r_valid_r <= 1'b0;
            r_err_r   <= 1'b0;
            r_rdata_r <= {BusWidth{1'b0}};
        end else begin
            r_valid_r <= 1'b0;
            r_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (host_req_i) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (host_we_i) begin
                            awaddr_r  <= aligned_addr_s;
                            wdata_r   <= host_wdata_i;
                            wstrb_r   <= host_be_i;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_REQ;
                        end else begin
                            araddr_r  <= aligned_addr_s;
                            arvalid_r <= 1'b1;
                            state_r   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; leave once both have been accepted.
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        bready_r <= 1'b1;
                        state_r  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_r  <= 1'b0;
                        r_valid_r <= 1'b1;
                        r_err_r   <= (m_axi_bresp != 2'b00);
                        r_rdata_r <= {BusWidth{1'b0}};
                        state_r   <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        rready_r  <= 1'b0;
                        r_valid_r <= 1'b1;
                        r_err_r   <= (m_axi_rresp != 2'b00);
                        r_rdata_r <= m_axi_rdata;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_sba_axil_bridge.md
# dm_sba_axil_bridge

Responder for the debug module's system-bus host port (req/gnt/r_valid protocol). Accepts one access at a time from the DM's `host_*` outputs and replays it as a single AXI4-Lite master transaction on the SoC interconnect. It returns read data and a completion pulse for both reads and writes. It sits between `dm_top` and the AXI-Lite crossbar, giving the debugger direct memory and peripheral access.

## Interface
- `BusWidth`, default 32: data/address width. Only 32 is supported; elaboration fails otherwise.
- `clk_i`  in  1  system clock, same clock as the DM.
- `rst_i`  in  1  synchronous, active-high reset.
- `host_req_i`  in  1  access request from the DM; held until granted.
- `host_add_i`  in  32  byte address.
- `host_we_i`  in  1  1 = write, 0 = read.
- `host_wdata_i`  in  32  write data, lane-aligned.
- `host_be_i`  in  4  byte enables.
- `host_gnt_o`  out  1  request accepted this cycle.
- `host_r_valid_o`  out  1  one-cycle completion pulse, for reads and writes.
- `host_r_rdata_o`  out  32  read data, valid with `host_r_valid_o`.
- `host_r_err_o`  out  1  AXI response was not OKAY; valid with `host_r_valid_o`.
- `m_axi_awaddr`  out  32
- `m_axi_awprot`  out  3  constant 3'b000.
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  32
- `m_axi_wstrb`  out  4
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_bresp`  in  2
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1
- `m_axi_araddr`  out  32
- `m_axi_arprot`  out  3  constant 3'b000.
- `m_axi_arvalid`  out  1
- `m_axi_arready`  in  1
- `m_axi_rdata`  in  32
- `m_axi_rresp`  in  2
- `m_axi_rvalid`  in  1
- `m_axi_rready`  out  1
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- **FSM states:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- **IDLE:**
  - `host_gnt_o` = `host_req_i`, combinational.
  - On grant, latch addr, we, wdata and be.
  - Next state is WR_REQ if we=1, else RD_REQ.
  - No request → stay in IDLE.
- **Address:** AXI address = `{host_add_i[31:2], 2'b00}`. Sub-word selection is carried only by `wstrb` = `host_be_i`. Reads always return the full aligned word; the DM extracts lanes itself.
- **WR_REQ:**
  - `awvalid` and `wvalid` are asserted together.
  - Each drops independently once its own handshake (valid & ready) completes, tracked by flags `aw_done`/`w_done`.
  - When both are done (same cycle or different cycles), go to WR_RESP.
  - Payload is held stable while valid is high.
- **WR_RESP:** `bready`=1. On `bvalid`, capture err = (`bresp` != 2'b00); go to DONE.
- **RD_REQ:** `arvalid`=1 until `arready`; then go to RD_RESP.
- **RD_RESP:** `rready`=1. On `rvalid`, capture `rdata` and err = (`rresp` != 2'b00); go to DONE.
- **DONE:**
  - `host_r_valid_o`=1 for exactly one cycle, with captured rdata/err; return to IDLE.
  - Write completions drive `host_r_rdata_o`=0.
- **Single outstanding access:**
  - `host_gnt_o`=0 in every state except IDLE.
  - A request arriving during DONE is granted at the earliest in the following IDLE cycle.
- **Error responses:** SLVERR/DECERR complete normally with err=1. No retry, no timeout.
- **Output register behaviour:**
  - `host_r_rdata_o` holds its last value between pulses.
  - `host_r_err_o` is 0 whenever `host_r_valid_o`=0.
- **Reset:** while `rst_i`=1, state → IDLE and every valid/ready/gnt/r_valid/busy output is 0. Reset values:
  - `host_r_rdata_o`=0, `host_r_err_o`=0.
  - AW/W/AR address and data outputs = 0.
  - `aw_done`/`w_done` cleared.
- **Reset mid-transaction:** the access is abandoned and no `host_r_valid_o` is generated. `rst_i` must also reset the AXI slave side.

## Timing
- **Grant:** same cycle as the request (cycle 0) when IDLE. All AXI outputs come from registers, so the first AXI valid appears in cycle 1.
- **Minimum latency, zero-wait slave:**
  - Write: AW/W handshake cycle 1, B cycle 2, `host_r_valid_o` cycle 3.
  - Read: AR cycle 1, R cycle 2, `host_r_valid_o` cycle 3.
- **Throughput:** back-to-back requests give a minimum 4-cycle request-to-request spacing (DONE → IDLE → grant).
- **Stalls:** each cycle of `awready`/`wready`/`arready`/`bvalid`/`rvalid` low adds one cycle of latency. The skew between AW and W acceptance adds max(skew) cycles, not the sum.
- **Ready behaviour:** `bready`/`rready` are asserted only in WR_RESP/RD_RESP. They never depend combinationally on `bvalid`/`rvalid`.

## Test plan
- **Read, zero-wait slave:** read from 0x8000_0004 returning 0xDEADBEEF → `araddr`=0x8000_0004 in cycle 1; `host_r_valid_o` in cycle 3 with rdata=0xDEADBEEF and err=0.
- **Byte write:** addr 0x1000_0003, be=4'b1000, wdata=0xAB00_0000 → `awaddr`=0x1000_0000, `wstrb`=4'b1000; one `host_r_valid_o` pulse with err=0.
- **AW/W skew:** `awready` delayed 5 cycles, `wready` immediate → `wvalid` drops after cycle 1, `awvalid` is held 6 cycles, exactly one AW and one W handshake occur; completion arrives in cycle 8.
- **Error response:** read answered with `rresp`=2'b10 → `host_r_valid_o`=1 and `host_r_err_o`=1; the next access completes with err=0.
- **Back-to-back with held request:** `host_req_i` held high across two accesses → `host_gnt_o` is low in all non-IDLE cycles, exactly two grants occur, and the second grant comes 4 cycles after the first.
- **Reset mid-read:** `rst_i` asserted during RD_RESP → next cycle all valids=0, `busy_o`=0, no `host_r_valid_o`; a new read after reset completes normally.
